// File: rtl/mac_pkg.sv
// Shared MAC receive constants, FSM state type and status bundle.
package mac_pkg;

  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    FRAME = 2'd2,
    DROP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic good;
    logic bad_crc;
    logic bad_len;
    logic err;
    logic ovf;
  } rx_stat_t;

endpackage

// File: rtl/mac_lfsr.sv
// Combinational Galois LFSR step over DATA_WIDTH input bits, optionally bit-reflected.
module mac_lfsr
  import mac_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = CRC_POLY,
  parameter bit                    REVERSE      = 1'b1,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_XOR_OUT = '0
) (
  input  logic [LFSR_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      r[i] = v[LFSR_WIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REFL = reflect(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] lfsr_s;

  // Reflected mode consumes data LSB first and shifts right.
  always_comb begin
    lfsr_s = state_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        lfsr_s = {1'b0, lfsr_s[LFSR_WIDTH-1:1]}
               ^ ({LFSR_WIDTH{lfsr_s[0] ^ data_in[i]}} & POLY_REFL);
      end else begin
        lfsr_s = {lfsr_s[LFSR_WIDTH-2:0], 1'b0}
               ^ ({LFSR_WIDTH{lfsr_s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i]}} & LFSR_POLY);
      end
    end
    state_out = lfsr_s ^ LFSR_XOR_OUT;
  end

endmodule

// File: rtl/mac_rx_frame_check.sv
// Ethernet receive frame checker: preamble/SFD detection, CRC and length checks,
// store-and-forward buffer with commit/rollback and an AXI-Stream style output.
module mac_rx_frame_check
  import mac_pkg::*;
#(
  parameter int BUF_DEPTH = 2048,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int STRIP_FCS = 1
) (
  input  logic       phy_rx_clk,
  input  logic       phy_rx_rst,
  input  logic [7:0] phy_rxd_in,
  input  logic       phy_rvalid_in,
  input  logic       phy_rerr_in,
  output logic [7:0] mac_rdata_out,
  output logic       mac_rvalid_out,
  input  logic       mac_rready_in,
  output logic       mac_rlast_out,
  output logic       stat_good_out,
  output logic       stat_bad_crc_out,
  output logic       stat_bad_len_out,
  output logic       stat_err_out,
  output logic       stat_ovf_out
);

  localparam int          AW      = $clog2(BUF_DEPTH);
  localparam int          DL      = (STRIP_FCS != 0) ? 5 : 1;
  localparam logic [2:0]  DL_FULL = 3'(DL);
  localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_CNT = 16'(MAX_FRAME + 1);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  rx_state_e          state_q, state_d;
  logic [31:0]        crc_q, crc_d, crc_next_s;
  logic [15:0]        cnt_q, cnt_d, cnt_inc_s;
  logic               err_q, err_d;
  logic [DL-1:0][7:0] dl_q, dl_d;
  logic [2:0]         dl_cnt_q, dl_cnt_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        commit_ptr_q, commit_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  rx_stat_t           stat_q, stat_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rlast_q, rlast_d;
  logic               rvalid_q, rvalid_d;
  logic               wr_en_s;
  logic [8:0]         wr_data_s;
  logic [8:0]         rd_word_s;
  logic               full_s;

  logic [8:0] mem [BUF_DEPTH];

  mac_lfsr #(
    .LFSR_WIDTH  (32),
    .LFSR_POLY   (CRC_POLY),
    .REVERSE     (1'b1),
    .DATA_WIDTH  (8),
    .LFSR_XOR_OUT(32'h0000_0000)
  ) u_crc (
    .state_in (crc_q),
    .data_in  (phy_rxd_in),
    .state_out(crc_next_s)
  );

  // Read-ahead into the output register frees its RAM slot, so full compares against rd_ptr.
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_word_s = mem[rd_ptr_q[AW-1:0]];

  // Receive FSM, frame checks and buffer write side.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    dl_d         = dl_q;
    dl_cnt_d     = dl_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en_s      = 1'b0;
    wr_data_s    = 9'h000;
    stat_d       = '0;
    cnt_inc_s    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (phy_rvalid_in && (phy_rxd_in == PREAMBLE_BYTE)) state_d = PRE;
        else                                                state_d = IDLE;
      end
      PRE: begin
        if (!phy_rvalid_in) begin
          state_d = IDLE;
        end else if (phy_rxd_in == PREAMBLE_BYTE) begin
          state_d = PRE;
        end else if (phy_rxd_in == SFD_BYTE) begin
          state_d  = FRAME;
          crc_d    = CRC_INIT;
          cnt_d    = 16'd0;
          err_d    = 1'b0;
          dl_cnt_d = 3'd0;
        end else begin
          state_d = DROP;
        end
      end
      FRAME: begin
        if (!phy_rvalid_in) begin
          state_d  = IDLE;
          wr_ptr_d = commit_ptr_q;
          if (err_q)                     stat_d.err     = 1'b1;
          else if (cnt_q < MIN_CNT)      stat_d.bad_len = 1'b1;
          else if (crc_q != CRC_RESIDUE) stat_d.bad_crc = 1'b1;
          else if (full_s)               stat_d.ovf     = 1'b1;
          else begin
            wr_en_s      = 1'b1;
            wr_data_s    = {1'b1, dl_q[DL-1]};
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            stat_d.good  = 1'b1;
          end
        end else begin
          crc_d = crc_next_s;
          cnt_d = cnt_inc_s;
          err_d = err_q | phy_rerr_in;
          for (int i = DL - 1; i > 0; i--) begin
            dl_d[i] = dl_q[i-1];
          end
          dl_d[0] = phy_rxd_in;
          if (dl_cnt_q != DL_FULL) dl_cnt_d = dl_cnt_q + 3'd1;
          else                     dl_cnt_d = dl_cnt_q;
          if (cnt_inc_s == MAX_CNT) begin
            state_d        = DROP;
            wr_ptr_d       = commit_ptr_q;
            stat_d.bad_len = 1'b1;
          end else if (dl_cnt_q == DL_FULL) begin
            if (full_s) begin
              state_d    = DROP;
              wr_ptr_d   = commit_ptr_q;
              stat_d.ovf = 1'b1;
            end else begin
              wr_en_s   = 1'b1;
              wr_data_s = {1'b0, dl_q[DL-1]};
              wr_ptr_d  = wr_ptr_q + PTR_ONE;
            end
          end else begin
            state_d = FRAME;
          end
        end
      end
      DROP: begin
        if (phy_rvalid_in) state_d = DROP;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: refill whenever empty or being consumed.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rlast_d  = rlast_q;
    if (!rvalid_q || mac_rready_in) begin
      if (rd_ptr_q != commit_ptr_q) begin
        rvalid_d           = 1'b1;
        {rlast_d, rdata_d} = rd_word_s;
        rd_ptr_d           = rd_ptr_q + PTR_ONE;
      end else begin
        rvalid_d = 1'b0;
      end
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State and pointer registers.
  always_ff @(posedge phy_rx_clk or posedge phy_rx_rst) begin
    if (phy_rx_rst) begin
      state_q      <= IDLE;
      crc_q        <= CRC_INIT;
      cnt_q        <= 16'd0;
      err_q        <= 1'b0;
      dl_q         <= '0;
      dl_cnt_q     <= 3'd0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      stat_q       <= '0;
      rdata_q      <= 8'h00;
      rlast_q      <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      dl_q         <= dl_d;
      dl_cnt_q     <= dl_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stat_q       <= stat_d;
      rdata_q      <= rdata_d;
      rlast_q      <= rlast_d;
      rvalid_q     <= rvalid_d;
    end
  end

  // Frame buffer write port.
  always_ff @(posedge phy_rx_clk) begin
    if (wr_en_s) mem[wr_ptr_q[AW-1:0]] <= wr_data_s;
  end

  assign mac_rdata_out    = rdata_q;
  assign mac_rvalid_out   = rvalid_q;
  assign mac_rlast_out    = rlast_q;
  assign stat_good_out    = stat_q.good;
  assign stat_bad_crc_out = stat_q.bad_crc;
  assign stat_bad_len_out = stat_q.bad_len;
  assign stat_err_out     = stat_q.err;
  assign stat_ovf_out     = stat_q.ovf;

endmodule

// File: tb/tb_mac_rx_frame_check.sv
// Scoreboard bench: frames are classified by a reference model when sent; monitors check outputs.
module tb_mac_rx_frame_check;

  localparam int BUF_DEPTH = 2048;
  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  localparam logic [4:0] EV_OVF  = 5'b00001;
  localparam logic [4:0] EV_ERR  = 5'b00010;
  localparam logic [4:0] EV_LEN  = 5'b00100;
  localparam logic [4:0] EV_CRC  = 5'b01000;
  localparam logic [4:0] EV_GOOD = 5'b10000;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic last; logic [7:0] data; } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] phy_rxd_in = 8'h00;
  logic phy_rvalid_in = 1'b0;
  logic phy_rerr_in = 1'b0;
  logic mac_rready_in = 1'b1;
  logic [7:0] mac_rdata_out;
  logic mac_rvalid_out, mac_rlast_out;
  logic stat_good_out, stat_bad_crc_out, stat_bad_len_out, stat_err_out, stat_ovf_out;
  logic [14:0] out_vec;
  logic [4:0] stat_vec;

  int n_tests = 0;
  int n_fail = 0;
  int ready_mode = 2;
  beat_t exp_q[$];
  logic [4:0] exp_stat_q[$];
  logic hold_pend = 1'b0;
  logic [8:0] hold_val = 9'h000;

  always #5 clk = ~clk;

  mac_rx_frame_check #(
    .BUF_DEPTH(BUF_DEPTH), .MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .STRIP_FCS(1)
  ) dut (
    .phy_rx_clk(clk), .phy_rx_rst(rst), .phy_rxd_in(phy_rxd_in),
    .phy_rvalid_in(phy_rvalid_in), .phy_rerr_in(phy_rerr_in),
    .mac_rdata_out(mac_rdata_out), .mac_rvalid_out(mac_rvalid_out),
    .mac_rready_in(mac_rready_in), .mac_rlast_out(mac_rlast_out),
    .stat_good_out(stat_good_out), .stat_bad_crc_out(stat_bad_crc_out),
    .stat_bad_len_out(stat_bad_len_out), .stat_err_out(stat_err_out),
    .stat_ovf_out(stat_ovf_out)
  );

  assign stat_vec = {stat_good_out, stat_bad_crc_out, stat_bad_len_out, stat_err_out, stat_ovf_out};
  assign out_vec  = {mac_rvalid_out, mac_rlast_out, mac_rdata_out, stat_vec};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Ethernet FCS: reflected CRC-32 over the bytes, complemented.
  function automatic logic [31:0] fcs32(input bq_t d, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    phy_rvalid_in = v;
    phy_rxd_in    = d;
    phy_rerr_in   = e;
  endtask

  // len counts DA..FCS; flip_bit < 0 and err_idx < 0 mean no corruption.
  task automatic send_frame(input int len, input int flip_bit, input int err_idx, input int gap);
    bq_t f;
    logic [31:0] fcs, rx_fcs;
    logic [4:0] code;
    int out_len;
    f = {};
    for (int i = 0; i < len - 4; i++) f.push_back(8'($urandom));
    fcs = fcs32(f, len - 4);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    if (flip_bit >= 0) f[flip_bit / 8] = f[flip_bit / 8] ^ 8'(1 << (flip_bit % 8));
    rx_fcs  = {f[len-1], f[len-2], f[len-3], f[len-4]};
    out_len = len - 4;
    if (len > MAX_FRAME)                        code = EV_LEN;
    else if (err_idx >= 0)                      code = EV_ERR;
    else if (len < MIN_FRAME)                   code = EV_LEN;
    else if (fcs32(f, len - 4) != rx_fcs)       code = EV_CRC;
    else if (exp_q.size() + out_len > BUF_DEPTH) code = EV_OVF;
    else begin
      code = EV_GOOD;
      for (int i = 0; i < out_len; i++) exp_q.push_back({(i == out_len - 1), f[i]});
    end
    exp_stat_q.push_back(code);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < len; i++) drive(1'b1, f[i], (i == err_idx));
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_stat_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    check("drain_beats_left", exp_q.size(), 0);
    check("drain_stats_left", exp_stat_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      mac_rready_in = 1'b0;
      else if (ready_mode == 2) mac_rready_in = 1'b1;
      else                      mac_rready_in = ($urandom_range(0, 3) != 0);
    end
  end

  // Output scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", mac_rvalid_out, 1);
        check("hold_beat", {mac_rlast_out, mac_rdata_out}, hold_val);
      end
      if (mac_rvalid_out && mac_rready_in) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_beat: got %0h, expected no beat", {mac_rlast_out, mac_rdata_out});
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", mac_rdata_out, e.data);
          check("out_last", mac_rlast_out, e.last);
        end
      end
      hold_pend = mac_rvalid_out && !mac_rready_in;
      hold_val  = {mac_rlast_out, mac_rdata_out};
    end
  end

  // Status pulse scoreboard.
  always @(negedge clk) begin
    if (!rst && stat_vec != 5'b00000) begin
      if (exp_stat_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_stat: got %05b, expected no pulse", stat_vec);
      end else begin
        check("stat_pulse", stat_vec, exp_stat_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", out_vec, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send_frame(64, -1, -1, 4);
    wait_drain(2000);
    send_frame(64, 8 * 20 + 3, -1, 2);
    send_frame(64, -1, -1, 1);
    wait_drain(2000);
    send_frame(64, -1, 63, 2);
    wait_drain(2000);
    send_frame(40, -1, -1, 2);
    send_frame(1600, -1, -1, 2);
    wait_drain(2000);
    send_frame(MIN_FRAME - 1, -1, -1, 1);
    send_frame(MIN_FRAME, -1, -1, 1);
    send_frame(MAX_FRAME, -1, -1, 1);
    send_frame(MAX_FRAME + 1, -1, -1, 1);
    wait_drain(4000);

    ready_mode = 0;
    send_frame(1000, -1, -1, 2);
    send_frame(1000, -1, -1, 2);
    send_frame(100, -1, -1, 2);
    repeat (20) @(posedge clk);
    ready_mode = 2;
    wait_drain(5000);

    ready_mode = 1;
    for (int k = 0; k < 24; k++) begin
      int len, flip, err, sel;
      len  = $urandom_range(MIN_FRAME, 300);
      sel  = $urandom_range(0, 5);
      flip = -1;
      err  = -1;
      if (sel == 0)      flip = $urandom_range(0, (len - 4) * 8 - 1);
      else if (sel == 1) err = $urandom_range(0, len - 1);
      else if (sel == 2) len = $urandom_range(MIN_FRAME - 20, MIN_FRAME - 1);
      if (exp_q.size() > 800) wait_drain(5000);
      send_frame(len, flip, err, $urandom_range(1, 3));
    end
    wait_drain(8000);

    ready_mode = 2;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b1, 8'($urandom), 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_midframe_outputs", out_vec, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 8'hA0, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    send_frame(80, -1, -1, 2);
    wait_drain(2000);

    ready_mode = 0;
    send_frame(100, -1, -1, 2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midout_valid_before_rst", mac_rvalid_out, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_midout_outputs", out_vec, 0);
    exp_q.delete();
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send_frame(80, -1, -1, 2);
    wait_drain(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
